data_island_scheduler: RTL

//  Per-line sequencer for HDMI data islands. On each horizontal-blanking start it computes how many
//  32-pixel packets fit in the blanking, then steps through lead control, preamble, leading guard,
//  N packet periods and trailing guard. It drives packet_enable / packet_pixel_counter into the

---
 rtl/data_island_scheduler_if.sv | 33 +++
 rtl/data_island_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/data_island_scheduler_if.sv
// Handshake bundle between the line timing source, the data island scheduler and its consumers.
interface data_island_scheduler_if;
    logic        line_blank_start;
    logic [11:0] blank_length;
    logic [4:0]  packets_requested;
    logic [1:0]  mode;
    logic        packet_enable;
    logic [4:0]  packet_pixel_counter;
    logic        island_active;
    logic [4:0]  packets_this_line;

    modport master (
        output line_blank_start,
        output blank_length,
        output packets_requested,
        input  mode,
        input  packet_enable,
        input  packet_pixel_counter,
        input  island_active,
        input  packets_this_line
    );

    modport slave (
        input  line_blank_start,
        input  blank_length,
        input  packets_requested,
        output mode,
        output packet_enable,
        output packet_pixel_counter,
        output island_active,
        output packets_this_line
    );
endinterface

// File: rtl/data_island_scheduler.sv
// Per-line HDMI data island sequencer: sizes the island from the blanking length, then walks
// lead control, preamble, guard, packet periods and trailing guard.
module data_island_scheduler #(
    parameter int unsigned MAX_PACKETS  = 18,
    parameter int unsigned CTRL_LEAD    = 4,
    parameter int unsigned TAIL_RESERVE = 22
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    data_island_scheduler_if.slave  bus
);

    localparam int unsigned Overhead  = CTRL_LEAD + 8 + 2 + 2 + TAIL_RESERVE;
    localparam logic [11:0] OverheadW = 12'(Overhead);
    localparam logic [11:0] LeadLast  = 12'(CTRL_LEAD - 1);
    localparam logic [4:0]  MaxPkts   = 5'(MAX_PACKETS);

    localparam logic [1:0] ModeControl  = 2'd0;
    localparam logic [1:0] ModePreamble = 2'd1;
    localparam logic [1:0] ModeGuard    = 2'd2;
    localparam logic [1:0] ModeData     = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StPreamble,
        StGuardLead,
        StData,
        StGuardTrail
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] phase_q, phase_d;
    logic [4:0]  pkts_left_q, pkts_left_d;
    logic [4:0]  ptl_q, ptl_d;
    logic [11:0] avail;
    logic [4:0]  n_calc;

    // Guarded compare keeps the subtraction from wrapping on short blanking intervals.
    always_comb begin
        avail = 12'd0;
        if (bus.blank_length >= OverheadW) begin
            avail = (bus.blank_length - OverheadW) >> 5;
        end
        n_calc = (bus.packets_requested < MaxPkts) ? bus.packets_requested : MaxPkts;
        if (avail < {7'd0, n_calc}) begin
            n_calc = avail[4:0];
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q     <= StIdle;
            phase_q     <= 12'd0;
            pkts_left_q <= 5'd0;
            ptl_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pkts_left_q <= pkts_left_d;
            ptl_q       <= ptl_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 12'd1;
        pkts_left_d = pkts_left_q;
        ptl_d       = ptl_q;
        unique case (state_q)
            StIdle: begin
                phase_d = 12'd0;
                if (bus.line_blank_start) begin
                    ptl_d = n_calc;
                    if (n_calc != 5'd0) begin
                        state_d     = StLead;
                        pkts_left_d = n_calc;
                    end
                end
            end
            StLead: begin
                if (phase_q == LeadLast) begin
                    state_d = StPreamble;
                    phase_d = 12'd0;
                end
            end
            StPreamble: begin
                if (phase_q == 12'd7) begin
                    state_d = StGuardLead;
                    phase_d = 12'd0;
                end
            end
            StGuardLead: begin
                if (phase_q == 12'd1) begin
                    state_d = StData;
                    phase_d = 12'd0;
                end
            end
            StData: begin
                if (phase_q == 12'd31) begin
                    phase_d     = 12'd0;
                    pkts_left_d = pkts_left_q - 5'd1;
                    if (pkts_left_q == 5'd1) begin
                        state_d = StGuardTrail;
                    end
                end
            end
            StGuardTrail: begin
                if (phase_q == 12'd1) begin
                    state_d = StIdle;
                    phase_d = 12'd0;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = 12'd0;
            end
        endcase
    end

    always_comb begin
        bus.mode                 = ModeControl;
        bus.packet_enable        = 1'b0;
        bus.packet_pixel_counter = 5'd0;
        bus.island_active        = 1'b0;
        bus.packets_this_line    = ptl_q;
        unique case (state_q)
            StPreamble: begin
                bus.mode          = ModePreamble;
                bus.island_active = 1'b1;
            end
            StGuardLead: begin
                bus.mode          = ModeGuard;
                bus.island_active = 1'b1;
                bus.packet_enable = (phase_q == 12'd1);
            end
            StData: begin
                bus.mode                 = ModeData;
                bus.island_active        = 1'b1;
                bus.packet_pixel_counter = phase_q[4:0];
                // The final packet is already announced; no enable at its last pixel.
                bus.packet_enable        = (phase_q == 12'd31) && (pkts_left_q != 5'd1);
            end
            StGuardTrail: begin
                bus.mode          = ModeGuard;
                bus.island_active = 1'b1;
            end
            default: begin
                bus.mode = ModeControl;
            end
        endcase
    end

endmodule
